systolic_int_mac_stream: RTL

// Parametrised byte-serial outer-product accumulator: the next generation of the BF16 vector

---
 rtl/systolic_int_mac_stream_if.sv | 21 ++
 rtl/systolic_int_mac_stream.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/systolic_int_mac_stream_if.sv
// Pad-side bundle for systolic_int_mac_stream: mode select, load byte stream in, accumulator bytes out.
interface systolic_int_mac_stream_if;
   logic [1:0] mode;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       busy;
   logic       ovf;

   modport master (
      output mode, in_valid, in_byte,
      input  in_ready, out_byte, out_valid, busy, ovf
   );

   modport slave (
      input  mode, in_valid, in_byte,
      output in_ready, out_byte, out_valid, busy, ovf
   );
endinterface

// File: rtl/systolic_int_mac_stream.sv
// Byte-serial signed outer-product accumulator: stage A/B bytes, swap into a working copy,
// run one MAC per cycle into N*N accumulators, and stream the accumulators back out bytewise.
module systolic_int_mac_stream #(
   parameter int N  = 4,
   parameter int EW = 8,
   parameter int AW = 24
) (
   input logic                       clk,
   input logic                       rst_n,
   systolic_int_mac_stream_if.slave  bus
);
   localparam int EB  = EW / 8;
   localparam int AB  = AW / 8;
   localparam int LB  = 2 * N * EB;
   localparam int NN  = N * N;
   localparam int RB  = NN * AB;
   localparam int LPW = $clog2(LB);
   localparam int RPW = $clog2(RB);
   localparam int KW  = $clog2(NN);
   localparam int IW  = $clog2(N);

   localparam logic [1:0] M_IDLE  = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_READ  = 2'b10;
   localparam logic [1:0] M_CLEAR = 2'b11;

   logic [7:0]           stg [LB];
   logic signed [EW-1:0] wa  [N];
   logic signed [EW-1:0] wb  [N];
   logic [AW-1:0]        acc [NN];
   logic [LPW-1:0]       lptr;
   logic [RPW-1:0]       rptr;
   logic [KW-1:0]        k;
   logic                 full;
   logic                 busy_q;
   logic                 ovf_q;
   logic [7:0]           obyte;
   logic                 ovld;
   logic [1:0]           prev_mode;

   logic                 accept;
   logic                 swap;
   logic                 rd_entry;
   logic signed [EW-1:0] elem [2*N];
   logic [IW-1:0]        mi;
   logic [IW-1:0]        mj;
   logic signed [2*EW-1:0] prod;
   logic [AW:0]          sum;
   logic                 mac_ovf;
   logic [RPW-1:0]       rp;
   logic [RPW-1:0]       rp_next;
   logic [KW-1:0]        ci;
   logic [7:0]           rd_byte;

   assign bus.in_ready  = (bus.mode == M_LOAD) && !full;
   assign bus.out_byte  = obyte;
   assign bus.out_valid = ovld;
   assign bus.busy      = busy_q;
   assign bus.ovf       = ovf_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign swap   = full && !busy_q;

   // Reassemble staged bytes into elements, MSB byte first.
   always_comb begin
      for (int e = 0; e < 2 * N; e++) begin
         elem[e] = '0;
         for (int b = 0; b < EB; b++) begin
            elem[e] = (elem[e] << 8) | EW'(stg[e * EB + b]);
         end
      end
   end

   // One extra sum bit exposes signed overflow as a mismatch of the top two bits.
   always_comb begin
      mi      = IW'(32'(k) / N);
      mj      = IW'(32'(k) % N);
      prod    = wa[mi] * wb[mj];
      sum     = {acc[k][AW-1], acc[k]} + {{(AW + 1 - 2 * EW){prod[2*EW-1]}}, prod};
      mac_ovf = sum[AW] ^ sum[AW-1];
   end

   always_comb begin
      rd_entry = (bus.mode == M_READ) && (prev_mode != M_READ);
      rp       = rd_entry ? '0 : rptr;
      rp_next  = (rp == RPW'(RB - 1)) ? '0 : rp + 1'b1;
      ci       = KW'(32'(rp) / AB);
      rd_byte  = 8'(acc[ci] >> (8 * (AB - 1 - (32'(rp) % AB))));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int e = 0; e < LB; e++) stg[e] <= '0;
         for (int e = 0; e < N; e++) begin
            wa[e] <= '0;
            wb[e] <= '0;
         end
         for (int e = 0; e < NN; e++) acc[e] <= '0;
         lptr      <= '0;
         rptr      <= '0;
         k         <= '0;
         full      <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         obyte     <= '0;
         ovld      <= 1'b0;
         prev_mode <= M_IDLE;
      end else begin
         prev_mode <= bus.mode;
         ovld      <= 1'b0;
         if (bus.mode == M_CLEAR) begin
            for (int e = 0; e < NN; e++) acc[e] <= '0;
            ovf_q  <= 1'b0;
            lptr   <= '0;
            rptr   <= '0;
            full   <= 1'b0;
            busy_q <= 1'b0;
            k      <= '0;
         end else begin
            if (accept) begin
               stg[lptr] <= bus.in_byte;
               if (lptr == LPW'(LB - 1)) begin
                  lptr <= '0;
                  full <= 1'b1;
               end else begin
                  lptr <= lptr + 1'b1;
               end
            end
            // accept needs !full, so it never collides with a swap
            if (swap) begin
               for (int e = 0; e < N; e++) begin
                  wa[e] <= elem[e];
                  wb[e] <= elem[N + e];
               end
               full   <= 1'b0;
               busy_q <= 1'b1;
               k      <= '0;
            end else if (busy_q) begin
               acc[k] <= sum[AW-1:0];
               if (mac_ovf) ovf_q <= 1'b1;
               if (k == KW'(NN - 1)) begin
                  busy_q <= 1'b0;
                  k      <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            if (bus.mode == M_READ) begin
               if (!busy_q) begin
                  obyte <= rd_byte;
                  ovld  <= 1'b1;
                  rptr  <= rp_next;
               end else if (rd_entry) begin
                  rptr <= '0;
               end
            end
         end
      end
   end
endmodule
